// File: rtl/rob_param_pkg.sv
// Reorder buffer shared definitions.
// Op encodings and the reserved "no entry" ID.
package rob_param_pkg;

   typedef enum logic [1:0] {
      ROB_OP_JALR   = 2'b00,
      ROB_OP_BRANCH = 2'b01,
      ROB_OP_OTHER  = 2'b10,
      ROB_OP_HALT   = 2'b11
   } rob_op_e;

   // ID 0 never names an entry; entries are 1..DEPTH.
   localparam int ROB_ID_NONE = 0;

endpackage

// File: rtl/rob_wb_select.sv
// Priority select across the write-back ports for one ID.
// The lowest-numbered port carrying a matching ID wins.
module rob_wb_select
   import rob_param_pkg::*;
#(
   parameter int NUM_WB = 3,
   parameter int ID_W   = 5
) (
   input  logic [ID_W-1:0]        id_i,
   input  logic [NUM_WB*ID_W-1:0] wb_id_i,
   input  logic [NUM_WB*32-1:0]   wb_value_i,
   input  logic [NUM_WB-1:0]      wb_taken_i,
   output logic                   hit_o,
   output logic [31:0]            value_o,
   output logic                   taken_o
);

   // Scan high to low so the lowest matching port is applied last.
   always_comb begin
      hit_o   = 1'b0;
      value_o = '0;
      taken_o = 1'b0;
      for (int k = NUM_WB - 1; k >= 0; k--) begin
         if (id_i != ID_W'(ROB_ID_NONE) &&
             wb_id_i[k*ID_W +: ID_W] == id_i) begin
            hit_o   = 1'b1;
            value_o = wb_value_i[k*32 +: 32];
            taken_o = wb_taken_i[k];
         end
      end
   end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate and commit,
// out-of-order write-back, branch/JALR resolution at commit.
module rob_param
   import rob_param_pkg::*;
#(
   parameter int          DEPTH    = 31,
   parameter int          NUM_WB   = 3,
   parameter int          ID_W     = $clog2(DEPTH + 1),
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   alloc_valid,
   output logic                   alloc_ready,
   output logic [ID_W-1:0]        alloc_id,
   input  logic [1:0]             alloc_op,
   input  logic                   alloc_value_ready,
   input  logic [31:0]            alloc_value,
   input  logic [31:0]            alloc_alt_value,
   input  logic [31:0]            alloc_pred_target,
   input  logic                   alloc_pred_taken,
   input  logic [4:0]             alloc_dest,
   input  logic [NUM_WB*ID_W-1:0] wb_id,
   input  logic [NUM_WB*32-1:0]   wb_value,
   input  logic [NUM_WB-1:0]      wb_taken,
   input  logic [2*ID_W-1:0]      q_id,
   output logic [1:0]             q_ready,
   output logic [63:0]            q_value,
   output logic                   rf_we,
   output logic [4:0]             rf_rd,
   output logic [31:0]            rf_data,
   output logic [ID_W-1:0]        commit_id,
   output logic                   flush_out,
   output logic                   fetch_pc_valid,
   output logic [31:0]            fetch_pc,
   output logic                   bp_update,
   output logic [31:0]            bp_pc,
   output logic                   bp_taken,
   output logic                   halt_out,
   output logic [ID_W-1:0]        count_out
);

   function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] p);
      return (p == ID_W'(DEPTH)) ? ID_W'(1) : p + ID_W'(1);
   endfunction

   logic [ID_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic            halt_q, flush_q;
   logic [DEPTH:1]  busy_q, rdy_q, ptk_q, tkn_q, wb_acc, e_hit, e_tkn;
   rob_op_e         op_q   [1:DEPTH];
   logic [31:0]     val_q  [1:DEPTH];
   logic [31:0]     alt_q  [1:DEPTH];
   logic [31:0]     pt_q   [1:DEPTH];
   logic [4:0]      dest_q [1:DEPTH];
   logic [31:0]     e_val  [1:DEPTH];
   logic [1:0]      q_hit, q_tkn_unused;
   logic [31:0]     q_fwd  [0:1];
   logic            fire, commit, mispredict;
   rob_op_e         h_op;
   logic [31:0]     h_val, h_alt, h_pt;

   assign alloc_id    = nxt(tail_q);
   assign alloc_ready = (count_q < ID_W'(DEPTH)) && !flush_q && !halt_q;
   assign fire        = alloc_valid && alloc_ready;
   assign count_out   = count_q;
   assign flush_out   = flush_q;
   assign halt_out    = halt_q;

   assign h_op   = op_q[head_q];
   assign h_val  = val_q[head_q];
   assign h_alt  = alt_q[head_q];
   assign h_pt   = pt_q[head_q];
   assign commit = busy_q[head_q] && rdy_q[head_q] && !halt_q;
   assign mispredict = commit &&
      ((h_op == ROB_OP_JALR && h_val != h_pt) ||
       (h_op == ROB_OP_BRANCH && tkn_q[head_q] != ptk_q[head_q]));

   for (genvar g = 1; g <= DEPTH; g++) begin : g_ent
      rob_wb_select #(.NUM_WB(NUM_WB), .ID_W(ID_W)) u_sel (
         .id_i       (ID_W'(g)),
         .wb_id_i    (wb_id),
         .wb_value_i (wb_value),
         .wb_taken_i (wb_taken),
         .hit_o      (e_hit[g]),
         .value_o    (e_val[g]),
         .taken_o    (e_tkn[g])
      );
      // A producer cannot hold the ID being handed out this cycle.
      assign wb_acc[g] = e_hit[g] && busy_q[g] && !rdy_q[g] &&
                         !(fire && alloc_id == ID_W'(g));
   end

   for (genvar j = 0; j < 2; j++) begin : g_q
      rob_wb_select #(.NUM_WB(NUM_WB), .ID_W(ID_W)) u_sel (
         .id_i       (q_id[j*ID_W +: ID_W]),
         .wb_id_i    (wb_id),
         .wb_value_i (wb_value),
         .wb_taken_i (wb_taken),
         .hit_o      (q_hit[j]),
         .value_o    (q_fwd[j]),
         .taken_o    (q_tkn_unused[j])
      );
   end

   // Operand query: stored value, else same-cycle write-back.
   always_comb begin
      q_ready = '0;
      q_value = '0;
      for (int j = 0; j < 2; j++) begin
         for (int i = 1; i <= DEPTH; i++) begin
            if (q_id[j*ID_W +: ID_W] == ID_W'(i) && busy_q[i]) begin
               if (rdy_q[i]) begin
                  q_ready[j]          = 1'b1;
                  q_value[j*32 +: 32] = val_q[i];
               end else if (q_hit[j]) begin
                  q_ready[j]          = 1'b1;
                  q_value[j*32 +: 32] = q_fwd[j];
               end
            end
         end
      end
   end

   // Pointer and occupancy next state; a mispredict rewinds everything.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (mispredict) begin
         head_d  = ID_W'(1);
         tail_d  = ID_W'(DEPTH);
         count_d = '0;
      end else begin
         if (commit) head_d = nxt(head_q);
         if (fire)   tail_d = alloc_id;
         count_d = count_q + ID_W'(fire) - ID_W'(commit);
      end
   end

   // Entry busy bits: set on allocate, cleared on retire or flush.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in || mispredict) begin
         busy_q <= '0;
      end else begin
         if (commit) busy_q[head_q] <= 1'b0;
         if (fire)   busy_q[alloc_id] <= 1'b1;
      end
   end

   // Entry payload: written at allocate, completed by write-back.
   always_ff @(posedge clk_in) begin
      for (int i = 1; i <= DEPTH; i++) begin
         if (fire && alloc_id == ID_W'(i)) begin
            op_q[i]   <= rob_op_e'(alloc_op);
            val_q[i]  <= alloc_value;
            alt_q[i]  <= alloc_alt_value;
            pt_q[i]   <= alloc_pred_target;
            ptk_q[i]  <= alloc_pred_taken;
            dest_q[i] <= alloc_dest;
            rdy_q[i]  <= alloc_value_ready;
            tkn_q[i]  <= 1'b0;
         end else if (wb_acc[i]) begin
            val_q[i] <= e_val[i];
            rdy_q[i] <= 1'b1;
            if (op_q[i] == ROB_OP_BRANCH) tkn_q[i] <= e_tkn[i];
         end
      end
   end

   // Pointers, halt and all registered commit/redirect outputs.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         head_q         <= ID_W'(1);
         tail_q         <= ID_W'(DEPTH);
         count_q        <= '0;
         halt_q         <= 1'b0;
         flush_q        <= 1'b1;
         fetch_pc_valid <= 1'b1;
         fetch_pc       <= RESET_PC;
         rf_we          <= 1'b0;
         rf_rd          <= '0;
         rf_data        <= '0;
         commit_id      <= '0;
         bp_update      <= 1'b0;
         bp_pc          <= '0;
         bp_taken       <= 1'b0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         flush_q        <= mispredict;
         fetch_pc_valid <= mispredict;
         if (mispredict) fetch_pc <= h_val;
         commit_id <= commit ? head_q : '0;
         rf_we     <= commit && (h_op == ROB_OP_OTHER || h_op == ROB_OP_JALR);
         if (commit && (h_op == ROB_OP_OTHER || h_op == ROB_OP_JALR)) begin
            rf_rd   <= dest_q[head_q];
            rf_data <= (h_op == ROB_OP_JALR) ? h_alt : h_val;
         end
         bp_update <= commit && h_op == ROB_OP_BRANCH;
         if (commit && h_op == ROB_OP_BRANCH) begin
            bp_pc    <= h_alt;
            bp_taken <= tkn_q[head_q];
         end
         if (commit && h_op == ROB_OP_HALT) halt_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param (DEPTH = 4, three write-back ports).
// Each task drives one scenario and checks hand-computed values.
module tb_rob_param;

   localparam int          DEPTH  = 4;
   localparam int          NUM_WB = 3;
   localparam int          ID_W   = 3;
   localparam logic [31:0] RPC    = 32'h0000_0080;

   logic                   clk_in = 1'b0;
   logic                   rst_n_in;
   logic                   alloc_valid;
   logic                   alloc_ready;
   logic [ID_W-1:0]        alloc_id;
   logic [1:0]             alloc_op;
   logic                   alloc_value_ready;
   logic [31:0]            alloc_value;
   logic [31:0]            alloc_alt_value;
   logic [31:0]            alloc_pred_target;
   logic                   alloc_pred_taken;
   logic [4:0]             alloc_dest;
   logic [NUM_WB*ID_W-1:0] wb_id;
   logic [NUM_WB*32-1:0]   wb_value;
   logic [NUM_WB-1:0]      wb_taken;
   logic [2*ID_W-1:0]      q_id;
   logic [1:0]             q_ready;
   logic [63:0]            q_value;
   logic                   rf_we;
   logic [4:0]             rf_rd;
   logic [31:0]            rf_data;
   logic [ID_W-1:0]        commit_id;
   logic                   flush_out;
   logic                   fetch_pc_valid;
   logic [31:0]            fetch_pc;
   logic                   bp_update;
   logic [31:0]            bp_pc;
   logic                   bp_taken;
   logic                   halt_out;
   logic [ID_W-1:0]        count_out;

   int cmp = 0;
   int bad = 0;

   rob_param #(
      .DEPTH(DEPTH), .NUM_WB(NUM_WB), .ID_W(ID_W), .RESET_PC(RPC)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_id(alloc_id), .alloc_op(alloc_op),
      .alloc_value_ready(alloc_value_ready), .alloc_value(alloc_value),
      .alloc_alt_value(alloc_alt_value),
      .alloc_pred_target(alloc_pred_target),
      .alloc_pred_taken(alloc_pred_taken), .alloc_dest(alloc_dest),
      .wb_id(wb_id), .wb_value(wb_value), .wb_taken(wb_taken),
      .q_id(q_id), .q_ready(q_ready), .q_value(q_value),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
      .commit_id(commit_id), .flush_out(flush_out),
      .fetch_pc_valid(fetch_pc_valid), .fetch_pc(fetch_pc),
      .bp_update(bp_update), .bp_pc(bp_pc), .bp_taken(bp_taken),
      .halt_out(halt_out), .count_out(count_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic alloc_set(input logic [1:0] op, input logic vr,
                            input logic [31:0] v, input logic [31:0] alt,
                            input logic [31:0] pt, input logic ptk,
                            input logic [4:0] d);
      alloc_valid       = 1'b1;
      alloc_op          = op;
      alloc_value_ready = vr;
      alloc_value       = v;
      alloc_alt_value   = alt;
      alloc_pred_target = pt;
      alloc_pred_taken  = ptk;
      alloc_dest        = d;
   endtask

   task automatic wb_set(input int k, input logic [ID_W-1:0] id,
                         input logic [31:0] v, input logic t);
      wb_id[k*ID_W +: ID_W] = id;
      wb_value[k*32 +: 32]  = v;
      wb_taken[k]           = t;
   endtask

   task automatic wb_clear();
      wb_id    = '0;
      wb_value = '0;
      wb_taken = '0;
   endtask

   task automatic do_reset();
      rst_n_in    = 1'b0;
      alloc_valid = 1'b0;
      q_id        = '0;
      wb_clear();
      tick();
      rst_n_in = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n_in    = 1'b0;
      alloc_valid = 1'b0;
      tick();
      tick();
      cmp++;
      if ({flush_out, fetch_pc_valid, fetch_pc} !== {1'b1, 1'b1, RPC}) begin
         bad++;
         $display("FAIL rst_fetch: got %b %b %h want 1 1 %h",
                  flush_out, fetch_pc_valid, fetch_pc, RPC);
      end
      cmp++;
      if ({rf_we, rf_rd, rf_data, commit_id} !== '0) begin
         bad++;
         $display("FAIL rst_rf: got %b %0d %h %0d want zeros",
                  rf_we, rf_rd, rf_data, commit_id);
      end
      cmp++;
      if ({bp_update, bp_pc, bp_taken, halt_out, count_out} !== '0) begin
         bad++;
         $display("FAIL rst_bp: got %b %h %b %b %0d want zeros",
                  bp_update, bp_pc, bp_taken, halt_out, count_out);
      end
      cmp++;
      if (alloc_ready !== 1'b0) begin
         bad++;
         $display("FAIL rst_ready: got %b want 0", alloc_ready);
      end
      rst_n_in = 1'b1;
      tick();
      cmp++;
      if ({flush_out, alloc_ready, alloc_id} !== {1'b0, 1'b1, 3'd1}) begin
         bad++;
         $display("FAIL rst_release: got %b %b %0d want 0 1 1",
                  flush_out, alloc_ready, alloc_id);
      end
   endtask

   task automatic test_in_order();
      do_reset();
      alloc_set(2'b10, 1'b1, 32'd7, 0, 0, 1'b0, 5'd5);
      tick();
      cmp++;
      if (count_out !== 3'd1) begin
         bad++;
         $display("FAIL io_count1: got %0d want 1", count_out);
      end
      alloc_set(2'b10, 1'b1, 32'd8, 0, 0, 1'b0, 5'd6);
      tick();
      cmp++;
      if ({commit_id, rf_we, rf_rd, rf_data} !== {3'd1, 1'b1, 5'd5, 32'd7}) begin
         bad++;
         $display("FAIL io_c1: got id%0d we%b x%0d %h want id1 we1 x5 7",
                  commit_id, rf_we, rf_rd, rf_data);
      end
      alloc_set(2'b10, 1'b1, 32'd9, 0, 0, 1'b0, 5'd7);
      tick();
      cmp++;
      if ({commit_id, rf_we, rf_rd, rf_data} !== {3'd2, 1'b1, 5'd6, 32'd8}) begin
         bad++;
         $display("FAIL io_c2: got id%0d we%b x%0d %h want id2 we1 x6 8",
                  commit_id, rf_we, rf_rd, rf_data);
      end
      alloc_valid = 1'b0;
      tick();
      cmp++;
      if ({commit_id, rf_we, rf_rd, rf_data} !== {3'd3, 1'b1, 5'd7, 32'd9}) begin
         bad++;
         $display("FAIL io_c3: got id%0d we%b x%0d %h want id3 we1 x7 9",
                  commit_id, rf_we, rf_rd, rf_data);
      end
      tick();
      cmp++;
      if ({commit_id, rf_we, count_out} !== '0) begin
         bad++;
         $display("FAIL io_empty: got id%0d we%b cnt%0d want 0 0 0",
                  commit_id, rf_we, count_out);
      end
   endtask

   task automatic test_ooo_wb();
      do_reset();
      alloc_set(2'b10, 1'b0, 0, 0, 0, 1'b0, 5'd10);
      tick();
      alloc_set(2'b10, 1'b0, 0, 0, 0, 1'b0, 5'd11);
      tick();
      alloc_valid = 1'b0;
      wb_set(1, 3'd2, 32'h22, 1'b0);
      tick();
      wb_clear();
      wb_set(0, 3'd1, 32'h11, 1'b0);
      q_id = {3'd1, 3'd2};
      #1;
      cmp++;
      if ({q_ready, q_value} !== {2'b11, 32'h11, 32'h22}) begin
         bad++;
         $display("FAIL ooo_query: got %b %h want 11 %h",
                  q_ready, q_value, {32'h11, 32'h22});
      end
      cmp++;
      if (commit_id !== 3'd0) begin
         bad++;
         $display("FAIL ooo_hold: got id%0d want 0", commit_id);
      end
      tick();
      wb_clear();
      q_id = '0;
      #1;
      cmp++;
      if ({commit_id, q_ready} !== {3'd0, 2'b00}) begin
         bad++;
         $display("FAIL ooo_wait: got id%0d q%b want id0 q00",
                  commit_id, q_ready);
      end
      tick();
      cmp++;
      if ({commit_id, rf_rd, rf_data} !== {3'd1, 5'd10, 32'h11}) begin
         bad++;
         $display("FAIL ooo_c1: got id%0d x%0d %h want id1 x10 11",
                  commit_id, rf_rd, rf_data);
      end
      tick();
      cmp++;
      if ({commit_id, rf_rd, rf_data} !== {3'd2, 5'd11, 32'h22}) begin
         bad++;
         $display("FAIL ooo_c2: got id%0d x%0d %h want id2 x11 22",
                  commit_id, rf_rd, rf_data);
      end
      cmp++;
      if (alloc_id !== 3'd3) begin
         bad++;
         $display("FAIL ooo_aid: got %0d want 3", alloc_id);
      end
      alloc_set(2'b10, 1'b0, 0, 0, 0, 1'b0, 5'd12);
      tick();
      alloc_valid = 1'b0;
      wb_set(0, 3'd3, 32'hAA, 1'b0);
      wb_set(2, 3'd3, 32'hCC, 1'b0);
      q_id = {3'd0, 3'd3};
      #1;
      cmp++;
      if ({q_ready, q_value[31:0]} !== {2'b01, 32'hAA}) begin
         bad++;
         $display("FAIL prio_query: got %b %h want 01 aa",
                  q_ready, q_value[31:0]);
      end
      tick();
      wb_clear();
      q_id = '0;
      tick();
      cmp++;
      if ({commit_id, rf_rd, rf_data} !== {3'd3, 5'd12, 32'hAA}) begin
         bad++;
         $display("FAIL prio_c3: got id%0d x%0d %h want id3 x12 aa",
                  commit_id, rf_rd, rf_data);
      end
   endtask

   task automatic test_branch();
      do_reset();
      alloc_set(2'b01, 1'b0, 0, 32'h100, 0, 1'b0, 5'd0);
      tick();
      alloc_valid = 1'b0;
      wb_set(2, 3'd1, 32'h200, 1'b1);
      tick();
      wb_clear();
      alloc_set(2'b10, 1'b1, 32'h99, 0, 0, 1'b0, 5'd4);
      tick();
      alloc_valid = 1'b0;
      cmp++;
      if ({flush_out, fetch_pc_valid, fetch_pc} !== {1'b1, 1'b1, 32'h200}) begin
         bad++;
         $display("FAIL br_flush: got %b %b %h want 1 1 200",
                  flush_out, fetch_pc_valid, fetch_pc);
      end
      cmp++;
      if ({bp_update, bp_pc, bp_taken, rf_we} !== {1'b1, 32'h100, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL br_bp: got %b %h %b we%b want 1 100 1 we0",
                  bp_update, bp_pc, bp_taken, rf_we);
      end
      cmp++;
      if ({commit_id, count_out, alloc_ready, alloc_id} !==
          {3'd1, 3'd0, 1'b0, 3'd1}) begin
         bad++;
         $display("FAIL br_rewind: got id%0d cnt%0d rdy%b aid%0d want 1 0 0 1",
                  commit_id, count_out, alloc_ready, alloc_id);
      end
      tick();
      cmp++;
      if ({flush_out, fetch_pc_valid, bp_update, commit_id, alloc_ready, alloc_id} !==
          {1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1}) begin
         bad++;
         $display("FAIL br_after: got %b %b %b id%0d rdy%b aid%0d want 0 0 0 0 1 1",
                  flush_out, fetch_pc_valid, bp_update, commit_id,
                  alloc_ready, alloc_id);
      end
      alloc_set(2'b01, 1'b0, 0, 32'h300, 0, 1'b1, 5'd0);
      tick();
      alloc_valid = 1'b0;
      wb_set(2, 3'd1, 32'h400, 1'b1);
      tick();
      wb_clear();
      tick();
      cmp++;
      if ({flush_out, bp_update, bp_pc, bp_taken, commit_id} !==
          {1'b0, 1'b1, 32'h300, 1'b1, 3'd1}) begin
         bad++;
         $display("FAIL br_ok: got fl%b %b %h %b id%0d want 0 1 300 1 1",
                  flush_out, bp_update, bp_pc, bp_taken, commit_id);
      end
   endtask

   task automatic test_jalr();
      do_reset();
      alloc_set(2'b00, 1'b0, 0, 32'h1004, 32'h40, 1'b0, 5'd1);
      tick();
      alloc_set(2'b00, 1'b0, 0, 32'h2004, 32'h40, 1'b0, 5'd2);
      tick();
      alloc_valid = 1'b0;
      wb_set(0, 3'd1, 32'h40, 1'b0);
      wb_set(1, 3'd2, 32'h44, 1'b0);
      tick();
      wb_clear();
      tick();
      cmp++;
      if ({flush_out, commit_id, rf_we, rf_rd, rf_data} !==
          {1'b0, 3'd1, 1'b1, 5'd1, 32'h1004}) begin
         bad++;
         $display("FAIL jalr_hit: got fl%b id%0d we%b x%0d %h want 0 1 1 x1 1004",
                  flush_out, commit_id, rf_we, rf_rd, rf_data);
      end
      tick();
      cmp++;
      if ({flush_out, fetch_pc_valid, fetch_pc} !== {1'b1, 1'b1, 32'h44}) begin
         bad++;
         $display("FAIL jalr_miss: got %b %b %h want 1 1 44",
                  flush_out, fetch_pc_valid, fetch_pc);
      end
      cmp++;
      if ({commit_id, rf_we, rf_rd, rf_data, count_out} !==
          {3'd2, 1'b1, 5'd2, 32'h2004, 3'd0}) begin
         bad++;
         $display("FAIL jalr_miss_rf: got id%0d we%b x%0d %h cnt%0d want 2 1 x2 2004 0",
                  commit_id, rf_we, rf_rd, rf_data, count_out);
      end
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int i = 1; i <= DEPTH; i++) begin
         cmp++;
         if (alloc_id !== 3'(i)) begin
            bad++;
            $display("FAIL full_aid: got %0d want %0d", alloc_id, i);
         end
         alloc_set(2'b10, 1'b0, 0, 0, 0, 1'b0, 5'(i));
         tick();
      end
      cmp++;
      if ({count_out, alloc_ready} !== {3'd4, 1'b0}) begin
         bad++;
         $display("FAIL full_stop: got cnt%0d rdy%b want 4 0",
                  count_out, alloc_ready);
      end
      wb_set(0, 3'd1, 32'h5, 1'b0);
      tick();
      wb_clear();
      cmp++;
      if (alloc_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_nobypass: got rdy%b want 0", alloc_ready);
      end
      tick();
      cmp++;
      if ({commit_id, count_out, alloc_ready, alloc_id} !==
          {3'd1, 3'd3, 1'b1, 3'd1}) begin
         bad++;
         $display("FAIL full_wrap: got id%0d cnt%0d rdy%b aid%0d want 1 3 1 1",
                  commit_id, count_out, alloc_ready, alloc_id);
      end
      alloc_valid = 1'b0;
   endtask

   task automatic test_halt_reset();
      do_reset();
      alloc_set(2'b10, 1'b1, 32'h55, 0, 0, 1'b0, 5'd9);
      tick();
      alloc_set(2'b11, 1'b1, 0, 0, 0, 1'b0, 5'd0);
      tick();
      alloc_set(2'b10, 1'b1, 32'h77, 0, 0, 1'b0, 5'd3);
      tick();
      alloc_valid = 1'b0;
      cmp++;
      if ({halt_out, commit_id, rf_we, alloc_ready} !==
          {1'b1, 3'd2, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL halt_ret: got h%b id%0d we%b rdy%b want 1 2 0 0",
                  halt_out, commit_id, rf_we, alloc_ready);
      end
      tick();
      cmp++;
      if ({halt_out, commit_id, rf_we, count_out, alloc_ready} !==
          {1'b1, 3'd0, 1'b0, 3'd1, 1'b0}) begin
         bad++;
         $display("FAIL halt_stick: got h%b id%0d we%b cnt%0d rdy%b want 1 0 0 1 0",
                  halt_out, commit_id, rf_we, count_out, alloc_ready);
      end
      rst_n_in = 1'b0;
      tick();
      cmp++;
      if ({flush_out, fetch_pc_valid, fetch_pc} !== {1'b1, 1'b1, RPC}) begin
         bad++;
         $display("FAIL mid_rst_fetch: got %b %b %h want 1 1 %h",
                  flush_out, fetch_pc_valid, fetch_pc, RPC);
      end
      cmp++;
      if ({rf_we, rf_rd, rf_data, commit_id, bp_update, bp_pc, bp_taken,
           halt_out, count_out} !== '0) begin
         bad++;
         $display("FAIL mid_rst_out: got we%b x%0d %h id%0d %b %h %b h%b cnt%0d want zeros",
                  rf_we, rf_rd, rf_data, commit_id, bp_update, bp_pc,
                  bp_taken, halt_out, count_out);
      end
      rst_n_in = 1'b1;
      tick();
      tick();
      cmp++;
      if ({commit_id, alloc_ready, alloc_id, flush_out} !==
          {3'd0, 1'b1, 3'd1, 1'b0}) begin
         bad++;
         $display("FAIL mid_rst_clean: got id%0d rdy%b aid%0d fl%b want 0 1 1 0",
                  commit_id, alloc_ready, alloc_id, flush_out);
      end
   endtask

   initial begin
      rst_n_in          = 1'b0;
      alloc_valid       = 1'b0;
      alloc_op          = 2'b10;
      alloc_value_ready = 1'b0;
      alloc_value       = '0;
      alloc_alt_value   = '0;
      alloc_pred_target = '0;
      alloc_pred_taken  = 1'b0;
      alloc_dest        = '0;
      q_id              = '0;
      wb_clear();
      test_reset();
      test_in_order();
      test_ooo_wb();
      test_branch();
      test_jalr();
      test_full_wrap();
      test_halt_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

endmodule
